// File: rtl/mem_map_pkg.sv
// Memory-map definitions shared by the load decoder and the store byte-enable encoder.
// Holds size codes, address classes, I/O offsets and the per-stage load metadata.
package mem_map_pkg;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    typedef enum logic [1:0] {
        MEM      = 2'd0,
        IO       = 2'd1,
        UNMAPPED = 2'd2
    } addr_class_t;

    localparam logic [3:0] IO_BASE = 4'b1000;

    localparam logic [7:0] IO_TX_CTRL = 8'h00;
    localparam logic [7:0] IO_RX_CTRL = 8'h04;
    localparam logic [7:0] IO_RX_DATA = 8'h0C;
    localparam logic [7:0] IO_CYCLE   = 8'h10;

    typedef struct packed {
        logic        valid;
        addr_class_t cls;
        logic [1:0]  offset;
        logic [2:0]  size;
        logic [31:0] io_word;
    } stage_t;

    // MEM wins the tie-break so a nonstandard io_base can never shadow data RAM.
    function automatic addr_class_t classify(input logic [3:0] addr_hi, input logic [3:0] io_base);
        if (!addr_hi[3] && addr_hi[0]) return MEM;
        if (addr_hi == io_base)        return IO;
        return UNMAPPED;
    endfunction

endpackage

// File: rtl/load_extract.sv
// Byte/halfword/word lane select with sign or zero extension; purely combinational.
// Halfword select uses offset[1] only, matching the store encoder's lane choice.
module load_extract
    import mem_map_pkg::*;
(
    input  logic [31:0] i_src,
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_size,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_src[7:0];
        case (i_offset)
            2'd0:    w_byte = i_src[7:0];
            2'd1:    w_byte = i_src[15:8];
            2'd2:    w_byte = i_src[23:16];
            default: w_byte = i_src[31:24];
        endcase
    end

    assign w_half = i_offset[1] ? i_src[31:16] : i_src[15:0];

    always_comb begin
        o_data = i_src;
        case (i_size)
            SZ_B:    o_data = {{24{w_byte[7]}}, w_byte};
            SZ_BU:   o_data = {24'b0, w_byte};
            SZ_H:    o_data = {{16{w_half[15]}}, w_half};
            SZ_HU:   o_data = {16'b0, w_half};
            default: o_data = i_src;
        endcase
    end

endmodule

// File: rtl/load_data_decoder.sv
// Load-side memory-stage decoder: classifies the address, carries metadata across the
// BRAM read latency, extracts the result, and owns the UART pop and the cycle counter.
module load_data_decoder
    import mem_map_pkg::*;
#(
    parameter int         READ_LATENCY = 1,
    parameter logic [3:0] IO_BASE      = mem_map_pkg::IO_BASE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [31:0] addr,
    input  logic [2:0]  size,
    output logic        d_enb,
    input  logic [31:0] d_dout,
    input  logic        uart_tx_ready,
    input  logic        uart_rx_valid,
    input  logic [7:0]  uart_rx_data,
    output logic        uart_rx_pop,
    output logic        load_valid,
    output logic [31:0] load_data
);

    logic [31:0] r_cycle_count;
    stage_t      r_stage [READ_LATENCY];

    logic        w_accept;
    addr_class_t w_cls;
    logic [31:0] w_io_word;
    stage_t      w_issue;
    stage_t      w_last;
    logic [31:0] w_src;
    logic [31:0] w_extracted;
    logic        w_unused_addr;

    assign w_unused_addr = ^addr[27:8];

    // Freezing the BRAM port together with the stages keeps d_dout aligned with its metadata.
    assign d_enb    = en;
    assign w_accept = load & en;
    assign w_cls    = classify(addr[31:28], IO_BASE);

    always_comb begin
        w_io_word = 32'h0;
        case (addr[7:0])
            IO_TX_CTRL: w_io_word = {31'b0, uart_tx_ready};
            IO_RX_CTRL: w_io_word = {31'b0, uart_rx_valid};
            IO_RX_DATA: w_io_word = uart_rx_valid ? {24'b0, uart_rx_data} : 32'h0;
            IO_CYCLE:   w_io_word = r_cycle_count;
            default:    w_io_word = 32'h0;
        endcase
    end

    assign uart_rx_pop = w_accept && !rst && (w_cls == IO) &&
                         (addr[7:0] == IO_RX_DATA) && uart_rx_valid;

    always_comb begin
        w_issue         = '0;
        w_issue.valid   = w_accept;
        w_issue.cls     = w_cls;
        w_issue.offset  = addr[1:0];
        w_issue.size    = size;
        w_issue.io_word = w_io_word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cycle_count <= 32'h0;
        end else begin
            r_cycle_count <= r_cycle_count + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_stage[i] <= '0;
            end
        end else if (en) begin
            r_stage[0] <= w_issue;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign w_last = r_stage[READ_LATENCY-1];

    always_comb begin
        case (w_last.cls)
            MEM:     w_src = d_dout;
            IO:      w_src = w_last.io_word;
            default: w_src = 32'h0;
        endcase
    end

    load_extract u_extract (
        .i_src    (w_src),
        .i_offset (w_last.offset),
        .i_size   (w_last.size),
        .o_data   (w_extracted)
    );

    assign load_valid = w_last.valid;
    assign load_data  = w_last.valid ? w_extracted : 32'h0;

endmodule

// File: tb/tb_load_data_decoder.sv
// Bench for load_data_decoder: latency-1 and latency-2 instances share one stimulus stream,
// each fed by its own BRAM model; a result model is checked every cycle plus literal vectors.
module tb_load_data_decoder;

    logic        clk = 1'b0;
    logic        rst, en, load;
    logic [31:0] addr;
    logic [2:0]  size;
    logic        uart_tx_ready, uart_rx_valid;
    logic [7:0]  uart_rx_data;

    logic        d_enb1, d_enb2, pop1, pop2, lv1, lv2;
    logic [31:0] dout1, dout2, ld1, ld2;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit chk_on   = 1'b0;

    logic [31:0] mem [16];
    logic [31:0] q1, q2a, q2b;

    always #5 clk = ~clk;

    load_data_decoder #(.READ_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .load(load), .addr(addr), .size(size),
        .d_enb(d_enb1), .d_dout(dout1), .uart_tx_ready(uart_tx_ready),
        .uart_rx_valid(uart_rx_valid), .uart_rx_data(uart_rx_data),
        .uart_rx_pop(pop1), .load_valid(lv1), .load_data(ld1)
    );

    load_data_decoder #(.READ_LATENCY(2)) dut2 (
        .clk(clk), .rst(rst), .en(en), .load(load), .addr(addr), .size(size),
        .d_enb(d_enb2), .d_dout(dout2), .uart_tx_ready(uart_tx_ready),
        .uart_rx_valid(uart_rx_valid), .uart_rx_data(uart_rx_data),
        .uart_rx_pop(pop2), .load_valid(lv2), .load_data(ld2)
    );

    // Synchronous BRAMs with the two read latencies, gated by each DUT's port enable.
    always @(posedge clk) if (d_enb1) q1 <= mem[addr[5:2]];
    always @(posedge clk) if (d_enb2) begin q2a <= mem[addr[5:2]]; q2b <= q2a; end
    assign dout1 = q1;
    assign dout2 = q2b;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Result of a load computed straight from the memory-map and extension rules.
    function automatic logic [31:0] model_result(input logic [31:0] a, input logic [2:0] s,
                                                 input logic [31:0] memword, input logic [31:0] cnt,
                                                 input logic tx, input logic rxv, input logic [7:0] rxd);
        logic [31:0] src, r;
        int off;
        off = int'(a[1:0]);
        if (a[31] == 1'b0 && a[28] == 1'b1) src = memword;
        else if (a[31:28] == 4'h8) begin
            case (a[7:0])
                8'h00:   src = {31'b0, tx};
                8'h04:   src = {31'b0, rxv};
                8'h0C:   src = rxv ? {24'b0, rxd} : 32'h0;
                8'h10:   src = cnt;
                default: src = 32'h0;
            endcase
        end else src = 32'h0;
        case (s)
            3'b000, 3'b100: begin
                r = (src >> (8 * off)) & 32'hFF;
                if (s == 3'b000 && r[7]) r = r | 32'hFFFFFF00;
            end
            3'b001, 3'b101: begin
                r = (src >> ((off >= 2) ? 16 : 0)) & 32'hFFFF;
                if (s == 3'b001 && r[15]) r = r | 32'hFFFF0000;
            end
            default: r = src;
        endcase
        return r;
    endfunction

    // Expected-output delay lines: one slot per enabled clock of read latency.
    logic [31:0] cnt_m = 32'h0;
    bit          e1_v = 1'b0;
    logic [31:0] e1_d = 32'h0;
    bit          e2_v [2] = '{1'b0, 1'b0};
    logic [31:0] e2_d [2] = '{32'h0, 32'h0};

    always @(posedge clk or posedge rst) begin
        logic [31:0] res;
        if (rst) begin
            cnt_m = 32'h0;
            e1_v = 1'b0; e1_d = 32'h0;
            e2_v[0] = 1'b0; e2_v[1] = 1'b0; e2_d[0] = 32'h0; e2_d[1] = 32'h0;
        end else begin
            if (en) begin
                res = model_result(addr, size, mem[addr[5:2]], cnt_m,
                                   uart_tx_ready, uart_rx_valid, uart_rx_data);
                e2_v[1] = e2_v[0]; e2_d[1] = e2_d[0];
                e2_v[0] = load;    e2_d[0] = res;
                e1_v = load;       e1_d = res;
            end
            cnt_m = cnt_m + 32'd1;
        end
    end

    always @(negedge clk) begin
        logic exp_pop;
        if (chk_on) begin
            exp_pop = load && en && !rst && (addr[31:28] == 4'h8) &&
                      (addr[7:0] == 8'h0C) && uart_rx_valid;
            check("m_valid_l1", {31'b0, lv1}, {31'b0, e1_v});
            check("m_data_l1", ld1, e1_v ? e1_d : 32'h0);
            check("m_valid_l2", {31'b0, lv2}, {31'b0, e2_v[1]});
            check("m_data_l2", ld2, e2_v[1] ? e2_d[1] : 32'h0);
            check("m_pop_l1", {31'b0, pop1}, {31'b0, exp_pop});
            check("m_pop_l2", {31'b0, pop2}, {31'b0, exp_pop});
            check("m_enb_l1", {31'b0, d_enb1}, {31'b0, en});
            check("m_enb_l2", {31'b0, d_enb2}, {31'b0, en});
        end
    end

    logic [31:0] out1_q[$], out2_q[$];
    int          oc1_q[$], oc2_q[$];
    always @(negedge clk) begin
        if (lv1) begin out1_q.push_back(ld1); oc1_q.push_back(cyc); end
        if (lv2) begin out2_q.push_back(ld2); oc2_q.push_back(cyc); end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one load (called at posedge+1) and check pop, then the result of each latency.
    task automatic do_load(input string nm, input logic [31:0] a, input logic [2:0] s,
                           input logic [31:0] exp, input logic exp_pop);
        addr = a; size = s; load = 1'b1;
        @(negedge clk);
        check({nm, "_pop"}, {31'b0, pop1}, {31'b0, exp_pop});
        tick;
        load = 1'b0;
        @(negedge clk);
        check({nm, "_v1"}, {31'b0, lv1}, 32'h1);
        check({nm, "_d1"}, ld1, exp);
        tick;
        @(negedge clk);
        check({nm, "_v2"}, {31'b0, lv2}, 32'h1);
        check({nm, "_d2"}, ld2, exp);
        tick;
    endtask

    localparam logic [31:0] B2B_ADDR [5] = '{32'h10000008, 32'h80000004, 32'h40000000,
                                             32'h80000010, 32'h80000010};

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        rst = 1'b1; en = 1'b1; load = 1'b0; addr = 32'h0; size = 3'b010;
        uart_tx_ready = 1'b1; uart_rx_valid = 1'b0; uart_rx_data = 8'h00;
        tick;
        chk_on = 1'b1;
        // A pop-worthy load presented during reset must not pop.
        load = 1'b1; addr = 32'h8000000C; uart_rx_valid = 1'b1; uart_rx_data = 8'h5A;
        @(negedge clk);
        check("rst_pop", {31'b0, pop1}, 32'h0);
        check("rst_valid", {31'b0, lv1}, 32'h0);
        check("rst_data", ld1, 32'h0);
        tick;
        load = 1'b0; uart_rx_valid = 1'b0; rst = 1'b0;
        tick;

        mem[0] = 32'h80FF1234;
        do_load("lb_3",  32'h10000003, 3'b000, 32'hFFFFFF80, 1'b0);
        do_load("lbu_3", 32'h10000003, 3'b100, 32'h00000080, 1'b0);
        mem[0] = 32'h8001ABCD;
        do_load("lh_2",  32'h10000002, 3'b001, 32'hFFFF8001, 1'b0);
        do_load("lhu_1", 32'h10000001, 3'b101, 32'h0000ABCD, 1'b0);
        do_load("lw_0",  32'h10000000, 3'b010, 32'h8001ABCD, 1'b0);
        do_load("lb_1",  32'h10000001, 3'b000, 32'hFFFFFFAB, 1'b0);
        do_load("lhu_3", 32'h10000003, 3'b101, 32'h00008001, 1'b0);
        do_load("rsv_3", 32'h10000000, 3'b011, 32'h8001ABCD, 1'b0);
        do_load("rsv_7", 32'h10000002, 3'b111, 32'h8001ABCD, 1'b0);
        do_load("unmap", 32'h40000000, 3'b010, 32'h00000000, 1'b0);
        do_load("io_tx", 32'h80000000, 3'b010, 32'h00000001, 1'b0);

        uart_rx_valid = 1'b1; uart_rx_data = 8'h5A;
        do_load("rx_pop", 32'h8000000C, 3'b010, 32'h0000005A, 1'b1);
        @(negedge clk);
        check("rx_no_pop_after", {31'b0, pop1}, 32'h0);
        tick;
        uart_rx_valid = 1'b0;
        do_load("rx_empty", 32'h8000000C, 3'b010, 32'h00000000, 1'b0);

        // Freeze with a result pending at the latency-1 output.
        addr = 32'h10000000; size = 3'b010; load = 1'b1;
        tick;
        load = 1'b0; en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("frz_v1", {31'b0, lv1}, 32'h1);
            check("frz_enb", {31'b0, d_enb1}, 32'h0);
            check("frz_d1", ld1, 32'h8001ABCD);
            check("frz_v2", {31'b0, lv2}, 32'h0);
            tick;
        end
        en = 1'b1;
        @(negedge clk);
        check("thaw_v1", {31'b0, lv1}, 32'h1);
        tick;
        @(negedge clk);
        check("thaw_v2", {31'b0, lv2}, 32'h1);
        check("thaw_d2", ld2, 32'h8001ABCD);
        tick;
        do_load("post_frz", 32'h10000001, 3'b100, 32'h000000AB, 1'b0);

        // Reset while loads are in flight in both pipelines.
        addr = 32'h10000000; size = 3'b010; load = 1'b1;
        tick;
        load = 1'b0; rst = 1'b1;
        #1;
        check("mid_rst_v1", {31'b0, lv1}, 32'h0);
        check("mid_rst_d1", ld1, 32'h0);
        tick;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_v1", {31'b0, lv1}, 32'h0);
            check("post_rst_v2", {31'b0, lv2}, 32'h0);
            tick;
        end

        // Back-to-back: MEM, IO rx status, unmapped, cycle counter twice.
        mem[2] = 32'hDEADBEEF; uart_rx_valid = 1'b1; uart_rx_data = 8'h33;
        out1_q.delete(); out2_q.delete(); oc1_q.delete(); oc2_q.delete();
        for (int i = 0; i < 5; i++) begin
            addr = B2B_ADDR[i]; size = 3'b010; load = 1'b1;
            tick;
        end
        load = 1'b0;
        repeat (3) tick;
        check("b2b_n1", out1_q.size(), 32'd5);
        check("b2b_n2", out2_q.size(), 32'd5);
        if (out1_q.size() == 5 && out2_q.size() == 5) begin
            check("b2b_mem", out1_q[0], 32'hDEADBEEF);
            check("b2b_rxv", out1_q[1], 32'h00000001);
            check("b2b_unm", out1_q[2], 32'h00000000);
            check("b2b_cnt_step", out1_q[4] - out1_q[3], 32'h1);
            check("b2b_span", oc1_q[4] - oc1_q[0], 32'd4);
            check("b2b_shift", oc2_q[0] - oc1_q[0], 32'd1);
            for (int i = 0; i < 5; i++) check("b2b_l2_same", out2_q[i], out1_q[i]);
        end

        @(negedge clk);
        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
